// File: rtl/demux_ctrl.sv
// Two-lane byte demultiplexer with strict lane alternation, backpressure and a saturating stall counter.
// Optional macro DEMUX_SKIP_FULL_EN lets a byte bypass a full target lane into the free one.
module demux_ctrl (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_in,
    input  logic       full0,
    input  logic       full1,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       sel,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   full_sel;
    logic   target;
    logic   accept;
    logic   stall;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        full_sel = sel ? full1 : full0;
`ifdef DEMUX_SKIP_FULL_EN
        ready_in = (state_q != INIT) && !(full0 && full1);
        target   = full_sel ? ~sel : sel;
`else
        ready_in = (state_q != INIT) && !full_sel;
        target   = sel;
`endif
        accept   = valid_in && ready_in;
        // A byte held through INIT is refused, so it counts as a stalled cycle too.
        stall    = valid_in && !ready_in;

        state_d  = RUN;
        if (state_q != INIT && stall) begin
            state_d = STALL;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= INIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    // NOTE: lane data registers are reset explicitly because their reset value is observable.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out0  <= 8'h00;
            data_out1  <= 8'h00;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            sel        <= 1'b0;
            stall_cnt  <= 8'h00;
        end else begin
            valid_out0 <= accept && (target == 1'b0);
            valid_out1 <= accept && (target == 1'b1);
            if (accept && target == 1'b0) begin
                data_out0 <= data_in;
            end
            if (accept && target == 1'b1) begin
                data_out1 <= data_in;
            end
            if (accept) begin
                sel <= ~target;
            end
            if (stall && stall_cnt != 8'hFF) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_ctrl.sv
// Self-checking bench for demux_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_demux_ctrl;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic       full0 = 1'b0;
    logic       full1 = 1'b0;
    logic [7:0] data_out0;
    logic [7:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       sel;
    logic [7:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit       m_init;
    bit       m_sel;
    bit [7:0] m_cnt;
    bit [7:0] m_d0, m_d1;
    bit       m_v0, m_v1;

`ifdef DEMUX_SKIP_FULL_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    demux_ctrl dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .full0      (full0),
        .full1      (full1),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .sel        (sel),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_init = 1'b1;
        m_sel  = 1'b0;
        m_cnt  = 8'h00;
        m_d0   = 8'h00;
        m_d1   = 8'h00;
        m_v0   = 1'b0;
        m_v1   = 1'b0;
    endtask

    // One clock: drive inputs, compare ready_in before the edge, compare registered outputs after it.
    task automatic cycle(input bit v, input bit [7:0] d, input bit f0, input bit f1);
        bit exp_ready, acc, tgt, fsel;
        valid_in = v;
        data_in  = d;
        full0    = f0;
        full1    = f1;
        #2;
        fsel = m_sel ? f1 : f0;
        if (m_init)    exp_ready = 1'b0;
        else if (SKIP) exp_ready = !(f0 && f1);
        else           exp_ready = !fsel;
        checks++;
        if (ready_in !== exp_ready) begin
            failures++;
            $display("FAIL ready_in: got %b expected %b at %0t", ready_in, exp_ready, $time);
        end
        acc  = v && exp_ready;
        tgt  = (SKIP && fsel) ? !m_sel : m_sel;
        m_v0 = acc && !tgt;
        m_v1 = acc && tgt;
        if (m_v0) m_d0 = d;
        if (m_v1) m_d1 = d;
        if (acc) m_sel = !tgt;
        if (v && !exp_ready && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_init = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({valid_out0, valid_out1} !== {m_v0, m_v1}) begin
            failures++;
            $display("FAIL valid_out: got %b%b expected %b%b at %0t", valid_out0, valid_out1, m_v0, m_v1, $time);
        end
        checks++;
        if (data_out0 !== m_d0 || data_out1 !== m_d1) begin
            failures++;
            $display("FAIL data_out: got %h/%h expected %h/%h at %0t", data_out0, data_out1, m_d0, m_d1, $time);
        end
        checks++;
        if (sel !== m_sel) begin
            failures++;
            $display("FAIL sel: got %b expected %b at %0t", sel, m_sel, $time);
        end
        checks++;
        if (stall_cnt !== m_cnt) begin
            failures++;
            $display("FAIL stall_cnt: got %h expected %h at %0t", stall_cnt, m_cnt, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({data_out0, data_out1, valid_out0, valid_out1, sel, stall_cnt, ready_in} !== 29'd0) begin
            failures++;
            $display("FAIL %s: got d0=%h d1=%h v=%b%b sel=%b cnt=%h rdy=%b expected all 0", tag,
                     data_out0, data_out1, valid_out0, valid_out1, sel, stall_cnt, ready_in);
        end
    endtask

    // Hold reset across one posedge, release mid-cycle.
    task automatic apply_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        full0    = 1'b0;
        full1    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset_state");
        apply_reset();
    endtask

    task automatic test_init_alternation();
        apply_reset();
        cycle(1, 8'hFF, 0, 0);
        cycle(1, 8'hFF, 0, 0);
        cycle(1, 8'hEE, 0, 0);
        cycle(1, 8'hDD, 0, 0);
        cycle(1, 8'hCC, 0, 0);
        cycle(0, 8'h00, 0, 0);
        checks++;
        if (data_out0 !== 8'hDD || data_out1 !== 8'hCC || stall_cnt !== 8'd1) begin
            failures++;
            $display("FAIL init_seq: got d0=%h d1=%h cnt=%h expected DD CC 01", data_out0, data_out1, stall_cnt);
        end
    endtask

    task automatic test_gaps();
        cycle(1, 8'h03, 0, 0);
        cycle(1, 8'h04, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(1, 8'hAA, 0, 0);
        checks++;
        if (valid_out0 !== 1'b1 || data_out0 !== 8'hAA) begin
            failures++;
            $display("FAIL gap_alternation: got v0=%b d0=%h expected 1 AA", valid_out0, data_out0);
        end
        cycle(1, 8'h99, 0, 0);
        cycle(0, 8'h00, 0, 0);
    endtask

    task automatic test_full_lane();
        bit [7:0] cnt_before;
        cycle(1, 8'h11, 0, 0);
        cnt_before = m_cnt;
        for (int i = 0; i < 3; i++) cycle(1, 8'h22, 0, 1);
        if (SKIP) begin
            checks++;
            if (data_out0 !== 8'h22 || sel !== 1'b1 || stall_cnt !== cnt_before) begin
                failures++;
                $display("FAIL skip_full: got d0=%h sel=%b cnt=%h expected 22 1 %h", data_out0, sel, stall_cnt, cnt_before);
            end
        end else begin
            checks++;
            if (stall_cnt !== cnt_before + 8'd3 || valid_out1 !== 1'b0) begin
                failures++;
                $display("FAIL stall_full: got cnt=%h v1=%b expected %h 0", stall_cnt, valid_out1, cnt_before + 8'd3);
            end
            cycle(1, 8'h22, 0, 0);
            checks++;
            if (valid_out1 !== 1'b1 || data_out1 !== 8'h22) begin
                failures++;
                $display("FAIL stall_release: got v1=%b d1=%h expected 1 22", valid_out1, data_out1);
            end
        end
        cycle(0, 8'h00, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) cycle(1, 8'h5A, 1, 1);
        checks++;
        if (stall_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL saturation: got %h expected FF", stall_cnt);
        end
        cycle(0, 8'h00, 0, 0);
    endtask

    task automatic test_async_reset();
        cycle(1, 8'h31, 0, 0);
        valid_in = 1'b1;
        data_in  = 8'h32;
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        cycle(1, 8'h77, 0, 0);
        cycle(1, 8'h77, 0, 0);
        checks++;
        if (valid_out0 !== 1'b1 || valid_out1 !== 1'b0 || data_out0 !== 8'h77) begin
            failures++;
            $display("FAIL post_reset_lane: got v=%b%b d0=%h expected 10 77", valid_out0, valid_out1, data_out0);
        end
        cycle(0, 8'h00, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init_alternation();
        test_gaps();
        test_full_lane();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_ctrl.md
DEMUX_CTRL -- requirements
Module: demux_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all flops rise on the posedge.
REQ-002 The block SHALL have port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port data_in, input, 8 bits: incoming data byte.
REQ-004 The block SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-005 The block SHALL have port ready_in, output, 1 bit: the block accepts data_in this cycle (combinational from state, sel and full0/full1).
REQ-006 The block SHALL have port full0, input, 1 bit: lane-0 downstream buffer is full.
REQ-007 The block SHALL have port full1, input, 1 bit: lane-1 downstream buffer is full.
REQ-008 The block SHALL have ports data_out0 and data_out1, output, 8 bits each, registered: lane data.
REQ-009 The block SHALL have ports valid_out0 and valid_out1, output, 1 bit each, registered: lane write strobes.
REQ-010 The block SHALL have port sel, output, 1 bit, registered: lane that the next accepted byte targets.
REQ-011 The block SHALL have port stall_cnt, output, 8 bits, registered: count of stalled cycles.

Function
REQ-012 The FSM SHALL have states INIT, RUN and STALL.
REQ-013 INIT SHALL be held during reset, SHALL last exactly one clk after reset_L rises, then go to RUN; ready_in SHALL be 0 in INIT.
REQ-014 Accept SHALL mean valid_in=1 and ready_in=1 on a posedge.
REQ-015 In RUN or STALL, an accept SHALL, on the same posedge, load data_in into data_out[target] and set valid_out[target]=1, giving 1-cycle latency.
REQ-016 The non-target lane SHALL drive valid_out=0 and hold its data_out.
REQ-017 On a cycle without an accept, both valid_out SHALL be 0 and both data_out SHALL hold their values.
REQ-018 After each accept, sel SHALL become the inverse of the lane just written (strict alternation); without an accept, sel SHALL hold.
REQ-019 On a posedge with valid_in=1 and ready_in=0 (outside INIT), the FSM SHALL go to or stay in STALL, and stall_cnt SHALL increment, saturating at 8'hFF.
REQ-020 On any posedge that is not a stall (as defined in REQ-019), the FSM SHALL be in RUN after that edge.
REQ-021 stall_cnt SHALL never wrap and SHALL clear only on reset.
REQ-022 Lane fullness SHALL be sampled combinationally from full0/full1 in the same cycle; no data byte SHALL ever be dropped or duplicated.

Reset
REQ-023 While reset_L=0, the block SHALL asynchronously force: state=INIT, data_out0=data_out1=8'h00, valid_out0=valid_out1=0, sel=0, stall_cnt=8'h00, ready_in=0.
REQ-024 Asserting reset_L mid-transfer SHALL discard any in-flight strobe immediately; the first accept after reset SHALL go to lane 0.

Configuration
REQ-025 Without macro DEMUX_SKIP_FULL_EN, ready_in SHALL equal (state!=INIT) and not full[sel], and the target lane SHALL always be sel.
REQ-026 With DEMUX_SKIP_FULL_EN defined, ready_in SHALL equal (state!=INIT) and not (full0 and full1).
REQ-027 With DEMUX_SKIP_FULL_EN defined, the target lane SHALL be sel if full[sel]=0, otherwise the other lane, and sel SHALL update per REQ-018 using the lane actually written.

Verification
REQ-028 The bench SHALL cover: reset_L low for 1 clk, released, valid_in=1 with FF,EE,DD,CC -> INIT cycle with ready_in=0, then lane0 gets FF,DD and lane1 gets EE,CC, each one cycle after accept, stall_cnt=1.
REQ-029 The bench SHALL cover: valid_in pulses 03,04, gap of 2 clks, then AA,99 -> alternation continues across gaps (03->L0, 04->L1, AA->L0, 99->L1) with valid_out=0 during gaps.
REQ-030 The bench SHALL cover: full1=1 for 3 clks while sel=1 and valid_in=1, without the macro -> ready_in=0, FSM in STALL, stall_cnt +3, no strobes, byte delivered to L1 once full1 drops.
REQ-031 The bench SHALL cover: the same stimulus with DEMUX_SKIP_FULL_EN -> byte goes to L0 immediately, sel=1 afterwards, stall_cnt unchanged.
REQ-032 The bench SHALL cover: full0=full1=1 with valid_in=1 for 300 clks -> stall_cnt saturates at FF with no wrap.
REQ-033 The bench SHALL cover: reset_L=0 asynchronously mid-stream -> all outputs 0 before the next posedge, and the first post-reset byte goes to L0.
